sha256_compress: RTL and testbench

Iterative SHA-256 compression engine that sits directly upstream of the eight 32-bit hash-state registers (H0..H7). It takes one 512-bit padded message block and the current chaining value, runs the 64 compression rounds, and presents the updated chaining value for the hash registers to capture. Message padding and block sequencing are handled by the controller above this block.

---
 rtl/sha256_pkg.sv | 45 ++++
 rtl/sha256_round.sv | 21 ++
 rtl/sha256_compress.sv | 133 +++++++++++++
 tb/tb_sha256_compress.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/sha256_pkg.sv
// Shared SHA-256 constants, FSM state type and bit-level round functions.
package sha256_pkg;

  typedef enum logic [1:0] {ST_IDLE, ST_ROUND, ST_FINAL} state_e;

  localparam logic [255:0] SHA256_IV =
    256'h6a09e667_bb67ae85_3c6ef372_a54ff53a_510e527f_9b05688c_1f83d9ab_5be0cd19;

  localparam logic [31:0] K [64] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };

  // Rotations are written as explicit slices so every width is exact.
  function automatic logic [31:0] big_sigma0(input logic [31:0] x);
    return {x[1:0], x[31:2]} ^ {x[12:0], x[31:13]} ^ {x[21:0], x[31:22]};
  endfunction

  function automatic logic [31:0] big_sigma1(input logic [31:0] x);
    return {x[5:0], x[31:6]} ^ {x[10:0], x[31:11]} ^ {x[24:0], x[31:25]};
  endfunction

  function automatic logic [31:0] small_sigma0(input logic [31:0] x);
    return {x[6:0], x[31:7]} ^ {x[17:0], x[31:18]} ^ {3'b000, x[31:3]};
  endfunction

  function automatic logic [31:0] small_sigma1(input logic [31:0] x);
    return {x[16:0], x[31:17]} ^ {x[18:0], x[31:19]} ^ {10'b0, x[31:10]};
  endfunction

  function automatic logic [31:0] ch(input logic [31:0] e, input logic [31:0] f, input logic [31:0] g);
    return (e & f) ^ (~e & g);
  endfunction

  function automatic logic [31:0] maj(input logic [31:0] a, input logic [31:0] b, input logic [31:0] c);
    return (a & b) ^ (a & c) ^ (b & c);
  endfunction

endpackage

// File: rtl/sha256_round.sv
// One combinational SHA-256 round; state packed {a,b,c,d,e,f,g,h}, a in the MSBs.
module sha256_round
  import sha256_pkg::*;
(
  input  logic [255:0] st_in,
  input  logic [31:0]  k,
  input  logic [31:0]  w,
  output logic [255:0] st_out
);

  logic [31:0] a, b, c, d, e, f, g, h;
  logic [31:0] t1, t2, a_n, e_n;

  assign {a, b, c, d, e, f, g, h} = st_in;
  assign t1  = h + big_sigma1(e) + ch(e, f, g) + k + w;
  assign t2  = big_sigma0(a) + maj(a, b, c);
  assign a_n = t1 + t2;
  assign e_n = d + t1;
  assign st_out = {a_n, a, b, c, e_n, e, f, g};

endmodule

// File: rtl/sha256_compress.sv
// Iterative SHA-256 compression engine feeding the H0..H7 hash registers.
// Define SHA256_UNROLL2_EN to run two chained rounds per clock.
//
// state    | meaning
// ST_IDLE  | ready; capture h_in/block_in on start
// ST_ROUND | one (or two) compression rounds per clock, t counts up
// ST_FINAL | add saved H to working vars into h_out, pulse done
module sha256_compress
  import sha256_pkg::*;
(
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  input  logic [511:0] block_in,
  input  logic [255:0] h_in,
  output logic         ready,
  output logic         busy,
  output logic         done,
  output logic [255:0] h_out
);

  state_e       state_q, state_d;
  logic [5:0]   t_q, t_d;
  logic [255:0] wk_q, wk_d;
  logic [255:0] hs_q, hs_d;
  logic [511:0] w_q, w_d;
  logic [255:0] h_out_q, h_out_d;
  logic         done_q, done_d;

  logic [255:0] rnd0_out, rnd_out;
  logic [511:0] w_next;
  logic [31:0]  w_tail0;

  // Window word i sits at w_q[511-32*i -: 32]; w_q[511:480] is W[t].
  assign w_tail0 = small_sigma1(w_q[63:32]) + w_q[223:192] + small_sigma0(w_q[479:448]) + w_q[511:480];

  sha256_round u_round0 (
    .st_in  (wk_q),
    .k      (K[t_q]),
    .w      (w_q[511:480]),
    .st_out (rnd0_out)
  );

`ifdef SHA256_UNROLL2_EN
  localparam logic [5:0] T_STEP = 6'd2;
  localparam logic [5:0] T_LAST = 6'd62;

  logic [5:0]   t_q1;
  logic [31:0]  w_tail1;
  logic [255:0] rnd1_out;

  assign t_q1    = t_q + 6'd1;
  // W[t+17] only needs words already in the window, so both tails are parallel.
  assign w_tail1 = small_sigma1(w_q[31:0]) + w_q[191:160] + small_sigma0(w_q[447:416]) + w_q[479:448];

  sha256_round u_round1 (
    .st_in  (rnd0_out),
    .k      (K[t_q1]),
    .w      (w_q[479:448]),
    .st_out (rnd1_out)
  );

  assign rnd_out = rnd1_out;
  assign w_next  = {w_q[447:0], w_tail0, w_tail1};
`else
  localparam logic [5:0] T_STEP = 6'd1;
  localparam logic [5:0] T_LAST = 6'd63;

  assign rnd_out = rnd0_out;
  assign w_next  = {w_q[479:0], w_tail0};
`endif

  always_comb begin
    state_d = state_q;
    t_d     = t_q;
    wk_d    = wk_q;
    hs_d    = hs_q;
    w_d     = w_q;
    h_out_d = h_out_q;
    done_d  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          wk_d    = h_in;
          hs_d    = h_in;
          w_d     = block_in;
          t_d     = '0;
          state_d = ST_ROUND;
        end
      end
      ST_ROUND: begin
        wk_d = rnd_out;
        w_d  = w_next;
        t_d  = t_q + T_STEP;
        if (t_q == T_LAST) state_d = ST_FINAL;
      end
      ST_FINAL: begin
        for (int i = 0; i < 8; i++) begin
          h_out_d[32*i +: 32] = hs_q[32*i +: 32] + wk_q[32*i +: 32];
        end
        done_d  = 1'b1;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      t_q     <= '0;
      wk_q    <= '0;
      hs_q    <= '0;
      w_q     <= '0;
      h_out_q <= SHA256_IV;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      t_q     <= t_d;
      wk_q    <= wk_d;
      hs_q    <= hs_d;
      w_q     <= w_d;
      h_out_q <= h_out_d;
      done_q  <= done_d;
    end
  end

  assign ready = (state_q == ST_IDLE);
  assign busy  = (state_q == ST_ROUND) || (state_q == ST_FINAL);
  assign done  = done_q;
  assign h_out = h_out_q;

endmodule

// File: tb/tb_sha256_compress.sv
// Self-checking bench: loop-based SHA-256 reference model, digest/latency scoreboard, per-cycle monitor.
module tb_sha256_compress;

`ifdef SHA256_UNROLL2_EN
  localparam int LAT = 33;
`else
  localparam int LAT = 65;
`endif

  localparam logic [255:0] IV =
    256'h6a09e667_bb67ae85_3c6ef372_a54ff53a_510e527f_9b05688c_1f83d9ab_5be0cd19;
  localparam logic [255:0] ABC_D =
    256'hba7816bf_8f01cfea_414140de_5dae2223_b00361a3_96177a9c_b410ff61_f20015ad;
  localparam logic [255:0] EMPTY_D =
    256'he3b0c442_98fc1c14_9afbf4c8_996fb924_27ae41e4_649b934c_a495991b_7852b855;
  localparam logic [255:0] TWO_D =
    256'h248d6a61_d20638b8_e5c02693_0c3e6039_a33ce459_64ff2167_f6ecedd4_19db06c1;
  localparam logic [511:0] ABC_B   = {32'h61626380, 416'h0, 32'h00000000, 32'h00000018};
  localparam logic [511:0] EMPTY_B = {32'h80000000, 480'h0};
  localparam logic [511:0] TWO_B1  = {32'h61626364, 32'h62636465, 32'h63646566, 32'h64656667,
                                      32'h65666768, 32'h66676869, 32'h6768696a, 32'h68696a6b,
                                      32'h696a6b6c, 32'h6a6b6c6d, 32'h6b6c6d6e, 32'h6c6d6e6f,
                                      32'h6d6e6f70, 32'h6e6f7071, 32'h80000000, 32'h00000000};
  localparam logic [511:0] TWO_B2  = {448'h0, 32'h00000000, 32'h000001c0};

  localparam logic [31:0] KT [64] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         start = 1'b0;
  logic [511:0] block_in = '0;
  logic [255:0] h_in = '0;
  logic         ready, busy, done;
  logic [255:0] h_out;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  bit mon_en = 1'b0;
  logic [255:0] last_h = IV;
  logic [255:0] exp_h [$];
  int           exp_c [$];

  sha256_compress dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .block_in (block_in),
    .h_in     (h_in),
    .ready    (ready),
    .busy     (busy),
    .done     (done),
    .h_out    (h_out)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [31:0] ror(input logic [31:0] x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction

  // Straight textbook compression: full 64-word schedule, then 64 rounds over v[0..7].
  function automatic logic [255:0] model(input logic [255:0] hin, input logic [511:0] blk);
    logic [31:0] w [64];
    logic [31:0] v [8];
    logic [31:0] s0, s1, t1, t2;
    logic [255:0] r;
    for (int i = 0; i < 16; i++) w[i] = blk[511 - 32*i -: 32];
    for (int i = 16; i < 64; i++) begin
      s0 = ror(w[i-15], 7) ^ ror(w[i-15], 18) ^ (w[i-15] >> 3);
      s1 = ror(w[i-2], 17) ^ ror(w[i-2], 19) ^ (w[i-2] >> 10);
      w[i] = w[i-16] + s0 + w[i-7] + s1;
    end
    for (int i = 0; i < 8; i++) v[i] = hin[255 - 32*i -: 32];
    for (int i = 0; i < 64; i++) begin
      t1 = v[7] + (ror(v[4], 6) ^ ror(v[4], 11) ^ ror(v[4], 25)) + ((v[4] & v[5]) ^ (~v[4] & v[6])) + KT[i] + w[i];
      t2 = (ror(v[0], 2) ^ ror(v[0], 13) ^ ror(v[0], 22)) + ((v[0] & v[1]) ^ (v[0] & v[2]) ^ (v[1] & v[2]));
      for (int j = 7; j > 0; j--) v[j] = v[j-1];
      v[4] = v[4] + t1;
      v[0] = t1 + t2;
    end
    for (int i = 0; i < 8; i++) r[255 - 32*i -: 32] = hin[255 - 32*i -: 32] + v[i];
    return r;
  endfunction

  function automatic logic [511:0] rand_block();
    logic [511:0] b;
    for (int i = 0; i < 16; i++) b[32*i +: 32] = $urandom;
    return b;
  endfunction

  function automatic logic [255:0] rand_h();
    logic [255:0] h;
    for (int i = 0; i < 8; i++) h[32*i +: 32] = $urandom;
    return h;
  endfunction

  task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] want);
    checks++;
    if (act !== want) begin
      errors++;
      $display("FAIL %s: got %h want %h (cycle %0d)", nm, act, want, cyc);
    end
  endtask

  // Per-cycle monitor: digest and done-cycle against the scoreboard, h_out hold, ready/busy.
  always @(negedge clk) begin
    if (mon_en && !reset) begin
      if (done) begin
        if (exp_h.size() == 0) begin
          chk("unexpected_done", {255'b0, done}, 256'd0);
        end else begin
          chk("digest", h_out, exp_h[0]);
          chk("done_cycle", cyc, exp_c[0]);
          last_h = exp_h.pop_front();
          void'(exp_c.pop_front());
        end
      end else begin
        chk("h_out_hold", h_out, last_h);
      end
      chk("ready", {255'b0, ready}, {255'b0, exp_h.size() == 0});
      chk("busy", {255'b0, busy}, {255'b0, exp_h.size() != 0});
    end
  end

  // Caller must be at a negedge; accepts at the next posedge once ready.
  task automatic send(input logic [255:0] h, input logic [511:0] b);
    int n = 0;
    while (!ready && n < 300) begin @(negedge clk); n++; end
    if (!ready) chk("send_wait_ready", {255'b0, ready}, 256'd1);
    start = 1'b1;
    h_in = h;
    block_in = b;
    @(posedge clk); #1;
    exp_h.push_back(model(h, b));
    exp_c.push_back(cyc + LAT);
    start = 1'b0;
    h_in = rand_h();
    block_in = rand_block();
  endtask

  task automatic wait_idle();
    int n = 0;
    @(negedge clk);
    while (exp_h.size() != 0 && n < 300) begin @(negedge clk); n++; end
    if (exp_h.size() != 0) begin
      chk("idle_timeout", exp_h.size(), 256'd0);
      exp_h.delete();
      exp_c.delete();
    end
  endtask

  task automatic wait_done();
    int n = 0;
    @(negedge clk);
    while (!done && n < 300) begin @(negedge clk); n++; end
    if (!done) chk("done_timeout", {255'b0, done}, 256'd1);
  endtask

  initial begin
    logic [255:0] hv;
    chk("model_abc", model(IV, ABC_B), ABC_D);
    chk("model_empty", model(IV, EMPTY_B), EMPTY_D);
    chk("model_two_block", model(model(IV, TWO_B1), TWO_B2), TWO_D);

    repeat (3) @(posedge clk);
    #1;
    chk("rst_ready", {255'b0, ready}, 256'd1);
    chk("rst_busy", {255'b0, busy}, 256'd0);
    chk("rst_done", {255'b0, done}, 256'd0);
    chk("rst_h_out", h_out, IV);
    reset = 1'b0;
    last_h = IV;
    mon_en = 1'b1;

    // "abc" and empty message
    @(negedge clk);
    send(IV, ABC_B);
    wait_idle();
    chk("abc_digest", h_out, ABC_D);
    send(IV, EMPTY_B);
    wait_idle();
    chk("empty_digest", h_out, EMPTY_D);

    // two-block chaining, block 2 issued in the done cycle
    send(IV, TWO_B1);
    wait_done();
    chk("b2b_ready", {255'b0, ready}, 256'd1);
    hv = h_out;
    send(hv, TWO_B2);
    wait_idle();
    chk("two_block_digest", h_out, TWO_D);

    // start pulses while busy must be ignored
    send(IV, ABC_B);
    repeat (9) @(negedge clk);
    start = 1'b1; h_in = rand_h(); block_in = rand_block();
    @(negedge clk);
    start = 1'b0;
    repeat (29) @(negedge clk);
    start = 1'b1; h_in = rand_h(); block_in = rand_block();
    @(negedge clk);
    start = 1'b0;
    wait_idle();
    chk("busy_start_digest", h_out, ABC_D);

    // start held high: next block accepted in the done cycle
    start = 1'b1; h_in = IV; block_in = EMPTY_B;
    @(posedge clk); #1;
    exp_h.push_back(model(IV, EMPTY_B));
    exp_c.push_back(cyc + LAT);
    wait_done();
    @(posedge clk); #1;
    exp_h.push_back(model(IV, EMPTY_B));
    exp_c.push_back(cyc + LAT);
    start = 1'b0;
    wait_idle();
    chk("held_start_digest", h_out, EMPTY_D);

    // reset during round 30
    send(rand_h(), rand_block());
    repeat (30) @(posedge clk);
    #1;
    reset = 1'b1;
    #1;
    chk("mid_rst_ready", {255'b0, ready}, 256'd1);
    chk("mid_rst_busy", {255'b0, busy}, 256'd0);
    chk("mid_rst_done", {255'b0, done}, 256'd0);
    chk("mid_rst_h_out", h_out, IV);
    exp_h.delete();
    exp_c.delete();
    last_h = IV;
    @(posedge clk); #1;
    reset = 1'b0;
    repeat (80) @(negedge clk);
    send(IV, ABC_B);
    wait_idle();
    chk("post_rst_abc", h_out, ABC_D);

    // randomized chaining values and blocks
    for (int i = 0; i < 6; i++) begin
      repeat ($urandom_range(0, 3)) @(negedge clk);
      send(rand_h(), rand_block());
      wait_idle();
    end

    mon_en = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
